// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control unit: FSM states and scoreboard slots.
package pipe_ctrl_pkg;

  localparam int unsigned RF_ALEN = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic               valid;
    logic [RF_ALEN-1:0] rd;
    logic               rf_wr;
    logic               is_load;
  } ctrl_slot_t;

endpackage

// File: rtl/ctrl_scoreboard.sv
// Tracks the destinations in flight in EX and MEM and flags load-use hazards
// against the instruction currently in ID.
module ctrl_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               bubble,
  input  ctrl_slot_t         id_slot,
  input  logic [RF_ALEN-1:0] rs1_addr,
  input  logic               rs1_used,
  input  logic [RF_ALEN-1:0] rs2_addr,
  input  logic               rs2_used,
  output logic               load_use_c
);

  ctrl_slot_t ex_slot;
  ctrl_slot_t mem_slot;

  // Slot pipeline: hold while frozen, otherwise shift ID->EX->MEM (EX may take a bubble).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else if (hold) begin
      ex_slot  <= ex_slot;
      mem_slot <= mem_slot;
    end else begin
      mem_slot <= ex_slot;
      ex_slot  <= bubble ? ctrl_slot_t'('0) : id_slot;
    end
  end

  // Only a load still in EX stalls; MEM results are forwarded and x0 is never a producer.
  always_comb begin
    load_use_c = 1'b0;
    if (id_slot.valid && ex_slot.valid && ex_slot.is_load && ex_slot.rf_wr &&
        (ex_slot.rd != '0)) begin
      load_use_c = (rs1_used && (rs1_addr == ex_slot.rd)) ||
                   (rs2_used && (rs2_addr == ex_slot.rd));
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: memory-wait freeze, branch squash,
// load-use stall and the timeout halt FSM.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ALEN        = 5,
  parameter int unsigned PLEN        = 64,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_id_valid,
  input  logic [ALEN-1:0] i_id_rs1_addr,
  input  logic            i_id_rs1_used,
  input  logic [ALEN-1:0] i_id_rs2_addr,
  input  logic            i_id_rs2_used,
  input  logic [ALEN-1:0] i_id_rd_addr,
  input  logic            i_id_rf_wr,
  input  logic            i_id_mem_rd,
  input  logic            i_ex_br_taken,
  input  logic [PLEN-1:0] i_ex_br_target,
  input  logic            i_mem_req,
  input  logic            i_dmem_ack,
  output logic            o_pc_en,
  output logic            o_ifid_en,
  output logic            o_ifid_flush,
  output logic            o_idex_bubble,
  output logic            o_exmem_en,
  output logic            o_memwb_en,
  output logic            o_pc_redirect,
  output logic [PLEN-1:0] o_pc_target,
  output logic            o_halt,
  output logic [1:0]      o_state
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_e state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          halt_nxt;
  logic          freeze_c;
  logic          bubble_c;
  logic          load_use_c;
  ctrl_slot_t    id_slot;

  assign id_slot = '{valid:   i_id_valid,
                     rd:      RF_ALEN'(i_id_rd_addr),
                     rf_wr:   i_id_rf_wr,
                     is_load: i_id_mem_rd};

  ctrl_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (freeze_c),
    .bubble     (bubble_c),
    .id_slot    (id_slot),
    .rs1_addr   (RF_ALEN'(i_id_rs1_addr)),
    .rs1_used   (i_id_rs1_used),
    .rs2_addr   (RF_ALEN'(i_id_rs2_addr)),
    .rs2_used   (i_id_rs2_used),
    .load_use_c (load_use_c)
  );

  // State, wait counter and sticky halt flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      o_halt   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      o_halt   <= halt_nxt;
    end
  end

  // Next state plus stage-control muxing: freeze > branch flush > load-use > advance.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    halt_nxt      = o_halt;
    freeze_c      = 1'b0;
    bubble_c      = 1'b0;
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_exmem_en    = 1'b1;
    o_memwb_en    = 1'b1;
    o_pc_redirect = 1'b0;
    o_pc_target   = '0;

    case (state)
      RUN: begin
        if (i_mem_req && !i_dmem_ack) begin
          freeze_c     = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (i_dmem_ack) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          freeze_c = 1'b1;
          if (wait_cnt == CW'(MEM_TIMEOUT)) begin
            state_nxt = HALT;
            halt_nxt  = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + CW'(1);
          end
        end
      end
      default: begin
        freeze_c  = 1'b1;
        state_nxt = HALT;
      end
    endcase

    if (freeze_c) begin
      o_pc_en    = 1'b0;
      o_ifid_en  = 1'b0;
      o_exmem_en = 1'b0;
      o_memwb_en = 1'b0;
    end else if (i_ex_br_taken) begin
      o_pc_redirect = 1'b1;
      o_pc_target   = i_ex_br_target;
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
      bubble_c      = 1'b1;
    end else if (load_use_c) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_bubble = 1'b1;
      bubble_c      = 1'b1;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors are queued as each
// step is driven and popped when the DUT outputs are sampled.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_id_valid;
  logic [4:0]  i_id_rs1_addr;
  logic        i_id_rs1_used;
  logic [4:0]  i_id_rs2_addr;
  logic        i_id_rs2_used;
  logic [4:0]  i_id_rd_addr;
  logic        i_id_rf_wr;
  logic        i_id_mem_rd;
  logic        i_ex_br_taken;
  logic [63:0] i_ex_br_target;
  logic        i_mem_req;
  logic        i_dmem_ack;
  logic        o_pc_en;
  logic        o_ifid_en;
  logic        o_ifid_flush;
  logic        o_idex_bubble;
  logic        o_exmem_en;
  logic        o_memwb_en;
  logic        o_pc_redirect;
  logic [63:0] o_pc_target;
  logic        o_halt;
  logic [1:0]  o_state;

  typedef struct packed {
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_en;
    logic        memwb_en;
    logic        redirect;
    logic [63:0] target;
    logic        halt;
    logic [1:0]  state;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.ALEN(5), .PLEN(64), .MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_id_valid     (i_id_valid),
    .i_id_rs1_addr  (i_id_rs1_addr),
    .i_id_rs1_used  (i_id_rs1_used),
    .i_id_rs2_addr  (i_id_rs2_addr),
    .i_id_rs2_used  (i_id_rs2_used),
    .i_id_rd_addr   (i_id_rd_addr),
    .i_id_rf_wr     (i_id_rf_wr),
    .i_id_mem_rd    (i_id_mem_rd),
    .i_ex_br_taken  (i_ex_br_taken),
    .i_ex_br_target (i_ex_br_target),
    .i_mem_req      (i_mem_req),
    .i_dmem_ack     (i_dmem_ack),
    .o_pc_en        (o_pc_en),
    .o_ifid_en      (o_ifid_en),
    .o_ifid_flush   (o_ifid_flush),
    .o_idex_bubble  (o_idex_bubble),
    .o_exmem_en     (o_exmem_en),
    .o_memwb_en     (o_memwb_en),
    .o_pc_redirect  (o_pc_redirect),
    .o_pc_target    (o_pc_target),
    .o_halt         (o_halt),
    .o_state        (o_state)
  );

  function automatic exp_t mk(logic pc, logic ifid, logic fl, logic bub, logic exm,
                              logic mwb, logic rdr, logic [63:0] tgt, logic hlt,
                              logic [1:0] st);
    exp_t e;
    e = '{pc_en: pc, ifid_en: ifid, ifid_flush: fl, idex_bubble: bub, exmem_en: exm,
          memwb_en: mwb, redirect: rdr, target: tgt, halt: hlt, state: st};
    return e;
  endfunction

  function automatic exp_t adv(logic [1:0] st);
    return mk(1, 1, 0, 0, 1, 1, 0, 64'h0, 0, st);
  endfunction

  function automatic exp_t stall(logic [1:0] st);
    return mk(0, 0, 0, 1, 1, 1, 0, 64'h0, 0, st);
  endfunction

  function automatic exp_t br(logic [63:0] t, logic [1:0] st);
    return mk(1, 1, 1, 1, 1, 1, 1, t, 0, st);
  endfunction

  function automatic exp_t frz(logic [1:0] st, logic h);
    return mk(0, 0, 0, 0, 0, 0, 0, 64'h0, h, st);
  endfunction

  // Queue the expectation, sample at the falling edge, then move past the next rising edge.
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    exp_t want;
    exp_q.push_back(e);
    @(negedge clk);
    got = mk(o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_exmem_en, o_memwb_en,
             o_pc_redirect, o_pc_target, o_halt, o_state);
    want = exp_q.pop_front();
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld);
    i_id_valid    = v;
    i_id_rs1_addr = rs1;
    i_id_rs1_used = u1;
    i_id_rs2_addr = rs2;
    i_id_rs2_used = u2;
    i_id_rd_addr  = rd;
    i_id_rf_wr    = wr;
    i_id_mem_rd   = ld;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    i_ex_br_taken  = 1'b0;
    i_ex_br_target = 64'h0;
    i_mem_req      = 1'b0;
    i_dmem_ack     = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    do_reset(2);
    step("reset", adv(0));

    // Load-use on rs1, one stall then release (MEM-stage match does not stall).
    set_id(1, 2, 1, 0, 0, 5, 1, 1);  step("ld_x5", adv(0));
    set_id(1, 5, 1, 1, 1, 6, 1, 0);  step("lu_stall", stall(0));
    step("lu_release", adv(0));

    // Load-use on rs2.
    set_id(1, 3, 1, 0, 0, 7, 1, 1);  step("ld_x7", adv(0));
    set_id(1, 1, 1, 7, 1, 8, 1, 0);  step("lu_rs2_stall", stall(0));
    step("lu_rs2_release", adv(0));

    // ALU producer, unused operands, x0 destination and invalid ID never stall.
    set_id(1, 8, 1, 0, 0, 9, 1, 0);  step("alu_no_stall", adv(0));
    set_id(1, 0, 0, 0, 0, 10, 1, 1); step("ld_x10", adv(0));
    set_id(1, 10, 0, 10, 0, 11, 1, 0); step("unused_rs_no_stall", adv(0));
    set_id(1, 2, 1, 0, 0, 0, 1, 1);  step("ld_x0", adv(0));
    set_id(1, 0, 1, 1, 1, 6, 1, 0);  step("x0_no_stall", adv(0));
    set_id(1, 2, 1, 0, 0, 12, 1, 1); step("ld_x12", adv(0));
    set_id(0, 12, 1, 0, 0, 13, 1, 0); step("invalid_id_no_stall", adv(0));

    // Taken branch, then branch coinciding with a load-use hazard.
    idle();
    i_ex_br_taken = 1'b1; i_ex_br_target = 64'h80;
    step("br_flush", br(64'h80, 0));
    i_ex_br_taken = 1'b0;
    set_id(1, 2, 1, 0, 0, 9, 1, 1);  step("ld_x9", adv(0));
    set_id(1, 9, 1, 1, 1, 10, 1, 0);
    i_ex_br_taken = 1'b1; i_ex_br_target = 64'h100;
    step("br_over_lu", br(64'h100, 0));
    i_ex_br_taken = 1'b0;
    step("after_br_no_stall", adv(0));

    // Memory wait with a load held in EX; hazard resolves on the ack cycle.
    set_id(1, 2, 1, 0, 0, 11, 1, 1); step("ld_x11", adv(0));
    set_id(1, 11, 1, 0, 0, 12, 1, 0);
    i_mem_req = 1'b1; i_dmem_ack = 1'b0;
    step("mw_req", frz(0, 0));
    step("mw_wait1", frz(1, 0));
    step("mw_wait2", frz(1, 0));
    i_dmem_ack = 1'b1;
    step("mw_ack_stall", stall(1));
    i_mem_req = 1'b0; i_dmem_ack = 1'b0;
    step("mw_after", adv(0));

    // Ack in the request cycle: no freeze.
    idle();
    i_mem_req = 1'b1; i_dmem_ack = 1'b1;
    step("ack_same", adv(0));
    i_mem_req = 1'b0; i_dmem_ack = 1'b0;
    step("ack_same_after", adv(0));

    // Branch held during a wait redirects only on the ack cycle.
    i_mem_req = 1'b1; i_ex_br_taken = 1'b1; i_ex_br_target = 64'h200;
    step("bw_req", frz(0, 0));
    step("bw_wait1", frz(1, 0));
    step("bw_wait2", frz(1, 0));
    i_dmem_ack = 1'b1;
    step("bw_ack", br(64'h200, 1));
    idle();
    step("bw_once", adv(0));

    // Reset in the middle of a wait discards the held load.
    set_id(1, 2, 1, 0, 0, 13, 1, 1); step("ld_x13", adv(0));
    idle();
    i_mem_req = 1'b1;
    step("rw_req", frz(0, 0));
    step("rw_wait", frz(1, 0));
    i_mem_req = 1'b0;
    do_reset(1);
    set_id(1, 13, 1, 0, 0, 14, 1, 0);
    step("rst_clears_slots", adv(0));

    // Timeout: four wait cycles, then sticky HALT until reset.
    idle();
    i_mem_req = 1'b1;
    step("to_req", frz(0, 0));
    for (int i = 1; i <= 4; i++) step($sformatf("to_wait%0d", i), frz(1, 0));
    step("to_halt", frz(2, 1));
    i_dmem_ack = 1'b1; i_ex_br_taken = 1'b1; i_ex_br_target = 64'h300;
    step("halt_sticky", frz(2, 1));
    idle();
    step("halt_stays", frz(2, 1));
    do_reset(1);
    step("halt_recover", adv(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
